// File: rtl/raw_timing_monitor.sv
// raw_timing_monitor: measures line length, lines per frame, per-frame checksum and frame count of an fv/lv/data stream, with sticky hlen/vlen/protocol error flags
module raw_timing_monitor #(
  parameter int word_width = 10,
  parameter int h_active = 1280,
  parameter int v_active = 720,
  parameter int cnt_width = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fv,
  input  logic                  lv,
  input  logic [word_width-1:0] data,
  input  logic                  clear_err,
  output logic [cnt_width-1:0]  line_len,
  output logic [cnt_width-1:0]  line_cnt,
  output logic [15:0]           frame_cnt,
  output logic [31:0]           checksum,
  output logic                  frame_done,
  output logic                  err_hlen,
  output logic                  err_vlen,
  output logic                  err_proto
);
  typedef enum logic [1:0] {SYNC, IDLE, FRAME, LINE} state_t;
  state_t r_state;
  logic r_fv, r_lv, r_fv_p, r_lv_p;
  logic [word_width-1:0] r_data;
  logic [cnt_width-1:0] r_pix, r_ln;
  logic [31:0] r_acc;
  logic w_fv_rise, w_fv_fall, w_lv_rise, w_lv_fall, w_line_end, w_frame_end;
  logic [cnt_width-1:0] w_pix_inc, w_ln_inc, w_ln_fin;
  logic [31:0] w_acc_add;
  always_ff @(posedge clk) begin
    r_fv <= fv;
    r_lv <= lv;
    r_data <= data;
    r_fv_p <= r_fv;
    r_lv_p <= r_lv;
  end
  always_comb begin
    w_fv_rise = r_fv & ~r_fv_p;
    w_fv_fall = ~r_fv & r_fv_p;
    w_lv_rise = r_lv & ~r_lv_p;
    w_lv_fall = ~r_lv & r_lv_p;
    w_line_end = (r_state == LINE) & (w_fv_fall | w_lv_fall);
    w_frame_end = ((r_state == FRAME) | (r_state == LINE)) & w_fv_fall;
    w_pix_inc = &r_pix ? r_pix : r_pix + cnt_width'(1);
    w_ln_inc = &r_ln ? r_ln : r_ln + cnt_width'(1);
    w_ln_fin = (r_state == LINE) ? w_ln_inc : r_ln;
    w_acc_add = r_acc + 32'(r_data);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SYNC;
      r_pix <= '0;
      r_ln <= '0;
      r_acc <= '0;
      line_len <= '0;
      line_cnt <= '0;
      frame_cnt <= '0;
      checksum <= '0;
      frame_done <= 1'b0;
      err_hlen <= 1'b0;
      err_vlen <= 1'b0;
      err_proto <= 1'b0;
    end else begin
      frame_done <= w_frame_end;
      if (w_line_end) begin
        line_len <= r_pix;
        r_ln <= w_ln_inc;
      end
      if (w_frame_end) begin
        line_cnt <= w_ln_fin;
        checksum <= r_acc;
        frame_cnt <= frame_cnt + 16'd1;
      end
      err_hlen <= (err_hlen & ~clear_err) | (w_line_end & (r_pix != cnt_width'(h_active)));
      err_vlen <= (err_vlen & ~clear_err) | (w_frame_end & (w_ln_fin != cnt_width'(v_active)));
      err_proto <= (err_proto & ~clear_err) | ((r_state != SYNC) & r_lv & ~r_fv);
      case (r_state)
        SYNC: if (!r_fv) r_state <= IDLE;
        IDLE: if (w_fv_rise) begin
          r_state <= FRAME;
          r_pix <= '0;
          r_ln <= '0;
          r_acc <= '0;
        end
        FRAME: if (w_fv_fall) r_state <= IDLE;
        else if (w_lv_rise) begin
          r_state <= LINE;
          r_pix <= cnt_width'(1);
          r_acc <= w_acc_add;
        end
        LINE: if (w_line_end) r_state <= w_fv_fall ? IDLE : FRAME;
        else if (r_lv) begin
          r_pix <= w_pix_inc;
          r_acc <= w_acc_add;
        end
        default: r_state <= SYNC;
      endcase
    end
  end
endmodule

// File: tb/tb_raw_timing_monitor.sv
// tb_raw_timing_monitor: randomized self-checking bench for raw_timing_monitor against a frame-level reference model
module tb_raw_timing_monitor;
  localparam int WW = 10, HA = 8, VA = 4, CW = 4;
  logic clk = 0, rst = 1, fv = 0, lv = 0, clear_err = 0;
  logic [WW-1:0] data = '0;
  logic [CW-1:0] line_len, line_cnt;
  logic [15:0] frame_cnt;
  logic [31:0] checksum;
  logic frame_done, err_hlen, err_vlen, err_proto;
  int total = 0, bad = 0, done_seen = 0;
  bit exp_h = 0, exp_v = 0, exp_p = 0;
  logic [15:0] exp_fc = 0;
  int exp_ll = 0;
  int lens[8];
  raw_timing_monitor #(.word_width(WW), .h_active(HA), .v_active(VA), .cnt_width(CW)) dut (
    .clk(clk), .rst(rst), .fv(fv), .lv(lv), .data(data), .clear_err(clear_err),
    .line_len(line_len), .line_cnt(line_cnt), .frame_cnt(frame_cnt), .checksum(checksum),
    .frame_done(frame_done), .err_hlen(err_hlen), .err_vlen(err_vlen), .err_proto(err_proto)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (frame_done) done_seen++;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic int sat(input int x);
    return x > 15 ? 15 : x;
  endfunction
  task automatic run_frame(input int nl, input bit rnd, input bit drop, input int clr_at, input string tag);
    logic [31:0] sum = 0;
    int d0 = done_seen;
    fv = 1;
    step();
    step();
    for (int l = 0; l < nl; l++) begin
      lv = 1;
      for (int p = 0; p < lens[l]; p++) begin
        data = rnd ? WW'($urandom_range(0, 1023)) : WW'(p);
        sum += 32'(data);
        step();
      end
      exp_ll = sat(lens[l]);
      if (l == clr_at) begin exp_h = 0; exp_v = 0; exp_p = 0; end
      if (lens[l] != HA) exp_h = 1;
      if (drop && l == nl - 1) begin
        fv = 0;
        lv = 0;
      end else begin
        lv = 0;
        step();
        if (l == clr_at) clear_err = 1;
        step();
        clear_err = 0;
        step();
        total++;
        if (line_len !== CW'(exp_ll)) begin bad++; $display("FAIL %s line%0d line_len got=%0d exp=%0d", tag, l, line_len, exp_ll); end
      end
    end
    fv = 0;
    repeat (6) step();
    exp_fc++;
    if (nl != VA) exp_v = 1;
    total += 8;
    if (done_seen - d0 != 1) begin bad++; $display("FAIL %s frame_done pulses got=%0d exp=1", tag, done_seen - d0); end
    if (line_cnt !== CW'(sat(nl))) begin bad++; $display("FAIL %s line_cnt got=%0d exp=%0d", tag, line_cnt, sat(nl)); end
    if (line_len !== CW'(exp_ll)) begin bad++; $display("FAIL %s final line_len got=%0d exp=%0d", tag, line_len, exp_ll); end
    if (checksum !== sum) begin bad++; $display("FAIL %s checksum got=%0d exp=%0d", tag, checksum, sum); end
    if (frame_cnt !== exp_fc) begin bad++; $display("FAIL %s frame_cnt got=%0d exp=%0d", tag, frame_cnt, exp_fc); end
    if (err_hlen !== exp_h) begin bad++; $display("FAIL %s err_hlen got=%0b exp=%0b", tag, err_hlen, exp_h); end
    if (err_vlen !== exp_v) begin bad++; $display("FAIL %s err_vlen got=%0b exp=%0b", tag, err_vlen, exp_v); end
    if (err_proto !== exp_p) begin bad++; $display("FAIL %s err_proto got=%0b exp=%0b", tag, err_proto, exp_p); end
  endtask
  task automatic test_clear(input string tag);
    clear_err = 1;
    step();
    clear_err = 0;
    step();
    exp_h = 0; exp_v = 0; exp_p = 0;
    total += 3;
    if (err_hlen !== 1'b0) begin bad++; $display("FAIL %s err_hlen got=%0b exp=0", tag, err_hlen); end
    if (err_vlen !== 1'b0) begin bad++; $display("FAIL %s err_vlen got=%0b exp=0", tag, err_vlen); end
    if (err_proto !== 1'b0) begin bad++; $display("FAIL %s err_proto got=%0b exp=0", tag, err_proto); end
  endtask
  task automatic test_reset();
    rst = 1;
    repeat (3) step();
    rst = 0;
    step();
    total += 8;
    if (line_len !== '0) begin bad++; $display("FAIL reset line_len got=%0d exp=0", line_len); end
    if (line_cnt !== '0) begin bad++; $display("FAIL reset line_cnt got=%0d exp=0", line_cnt); end
    if (frame_cnt !== '0) begin bad++; $display("FAIL reset frame_cnt got=%0d exp=0", frame_cnt); end
    if (checksum !== '0) begin bad++; $display("FAIL reset checksum got=%0d exp=0", checksum); end
    if (frame_done !== 1'b0) begin bad++; $display("FAIL reset frame_done got=%0b exp=0", frame_done); end
    if (err_hlen !== 1'b0) begin bad++; $display("FAIL reset err_hlen got=%0b exp=0", err_hlen); end
    if (err_vlen !== 1'b0) begin bad++; $display("FAIL reset err_vlen got=%0b exp=0", err_vlen); end
    if (err_proto !== 1'b0) begin bad++; $display("FAIL reset err_proto got=%0b exp=0", err_proto); end
  endtask
  task automatic test_nominal();
    for (int i = 0; i < 4; i++) lens[i] = HA;
    for (int f = 0; f < 3; f++) run_frame(VA, 0, 0, -1, "nominal");
    total += 2;
    if (checksum !== 32'd112) begin bad++; $display("FAIL nominal_const checksum got=%0d exp=112", checksum); end
    if (frame_cnt !== 16'd3) begin bad++; $display("FAIL nominal_const frame_cnt got=%0d exp=3", frame_cnt); end
  endtask
  task automatic test_short_line();
    lens = '{8, 7, 8, 8, 8, 8, 8, 8};
    run_frame(VA, 1, 0, -1, "short_line");
    lens[1] = 8;
    run_frame(VA, 1, 0, -1, "short_sticky");
    test_clear("short_clear");
  endtask
  task automatic test_wrong_lines();
    for (int i = 0; i < 8; i++) lens[i] = HA;
    run_frame(5, 1, 0, -1, "five_lines");
    test_clear("five_clear");
    run_frame(0, 1, 0, -1, "zero_lines");
    test_clear("zero_clear");
  endtask
  task automatic test_fv_with_lv();
    for (int i = 0; i < 8; i++) lens[i] = HA;
    run_frame(VA, 1, 1, -1, "fv_with_lv");
  endtask
  task automatic test_proto();
    fv = 0;
    lv = 1;
    repeat (3) step();
    lv = 0;
    repeat (3) step();
    exp_p = 1;
    total++;
    if (err_proto !== 1'b1) begin bad++; $display("FAIL proto err_proto got=%0b exp=1", err_proto); end
    test_clear("proto_clear");
  endtask
  task automatic test_clear_collision();
    lens = '{8, 7, 8, 8, 8, 8, 8, 8};
    run_frame(VA, 1, 0, 1, "clear_collision");
  endtask
  task automatic test_random();
    for (int f = 0; f < 10; f++) begin
      int nl = $urandom_range(0, 5);
      bit drop = nl > 0 && $urandom_range(0, 1) == 1;
      int clr = -1;
      for (int i = 0; i < 8; i++) lens[i] = $urandom_range(0, 1) == 1 ? HA : $urandom_range(1, 17);
      if (nl > 0 && $urandom_range(0, 2) == 0) clr = $urandom_range(0, nl - 1);
      if (drop && clr == nl - 1) clr = -1;
      run_frame(nl, 1, drop, clr, "random");
    end
    test_clear("random_clear");
  endtask
  task automatic test_mid_reset();
    int d0;
    fv = 1;
    step();
    step();
    lv = 1;
    repeat (8) begin data = WW'($urandom_range(0, 1023)); step(); end
    lv = 0;
    repeat (3) step();
    lv = 1;
    repeat (3) step();
    rst = 1;
    step();
    step();
    rst = 0;
    d0 = done_seen;
    exp_h = 0; exp_v = 0; exp_p = 0; exp_fc = 0; exp_ll = 0;
    repeat (5) step();
    lv = 0;
    repeat (3) step();
    lv = 1;
    repeat (8) step();
    lv = 0;
    repeat (3) step();
    fv = 0;
    repeat (6) step();
    total += 5;
    if (done_seen - d0 != 0) begin bad++; $display("FAIL mid_reset frame_done pulses got=%0d exp=0", done_seen - d0); end
    if (frame_cnt !== 16'd0) begin bad++; $display("FAIL mid_reset frame_cnt got=%0d exp=0", frame_cnt); end
    if (line_len !== '0) begin bad++; $display("FAIL mid_reset line_len got=%0d exp=0", line_len); end
    if (line_cnt !== '0) begin bad++; $display("FAIL mid_reset line_cnt got=%0d exp=0", line_cnt); end
    if (checksum !== '0) begin bad++; $display("FAIL mid_reset checksum got=%0d exp=0", checksum); end
    for (int i = 0; i < 8; i++) lens[i] = HA;
    run_frame(VA, 1, 0, -1, "post_reset");
  endtask
  initial begin
    test_reset();
    test_nominal();
    test_short_line();
    test_wrong_lines();
    test_fv_with_lv();
    test_proto();
    test_clear_collision();
    test_random();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/raw_timing_monitor.md
Name: raw_timing_monitor

Overview:
- Sits directly downstream of raw_colorbar_gen, on the same pixel clock, and consumes its fv/lv/data stream.
- Measures the line length and the lines per frame, and compares them with the expected active size.
- Accumulates a per-frame pixel checksum and counts frames.
- Flags protocol violations with sticky error bits, used for bring-up on silicon and as the reference checker in simulation.

Parameters:
- word_width, 10, pixel data width; must match the generator.
- h_active, 1280, expected active pixels per line.
- v_active, 720, expected active lines per frame.
- cnt_width, 12, width of the pixel and line counters; must satisfy 2^cnt_width > max(h_active, v_active).

Ports:
- clk  input  1  pixel clock (same clock as the generator).
- rst  input  1  synchronous reset, active-high.
- fv  input  1  frame valid from the generator.
- lv  input  1  line valid from the generator.
- data  input  word_width  pixel data, valid while fv&lv.
- clear_err  input  1  one-cycle pulse that clears all sticky error flags.
- line_len  output  cnt_width  pixel count of the most recently completed line.
- line_cnt  output  cnt_width  line count of the most recently completed frame.
- frame_cnt  output  16  number of completed frames; wraps at 16'hFFFF -> 0.
- checksum  output  32  mod-2^32 sum of all data words in the last completed frame.
- frame_done  output  1  one-cycle pulse when the frame results update.
- err_hlen  output  1  sticky: a line length differed from h_active.
- err_vlen  output  1  sticky: a frame line count differed from v_active.
- err_proto  output  1  sticky: lv was high while fv was low.

Behaviour:
- Reset values:
  - all outputs 0;
  - internal counters and accumulator 0;
  - FSM in SYNC.
- Input stage: fv, lv and data are registered once (fv_r, lv_r, data_r). All edge detection uses fv_r/lv_r against their previous values (fv_p, lv_p). Monitoring is therefore 1 cycle behind the pins.
- FSM states:
  - SYNC: wait for fv_r=0. Discards any frame already in progress at reset or after reset. Next state IDLE.
  - IDLE: fv_r rising -> FRAME; clears pix_cnt, ln_cnt and acc.
  - FRAME: lv_r rising -> LINE with pix_cnt cleared. fv_r falling -> frame end, then IDLE.
  - LINE: every cycle with lv_r=1, pix_cnt += 1 (saturates at all-ones) and acc += zero-extended data_r (wraps mod 2^32).
    - lv_r falling: line end, -> FRAME.
    - fv_r falling while in LINE: line end and frame end in the same cycle, -> IDLE.
- Line end, registered on the next edge:
  - line_len <= pix_cnt;
  - ln_cnt += 1 (saturating);
  - if pix_cnt != h_active then err_hlen <= 1.
- Frame end, registered on the next edge:
  - line_cnt <= ln_cnt, including a coincident line end;
  - checksum <= acc;
  - frame_cnt += 1;
  - frame_done = 1 for exactly one cycle;
  - if the final line count != v_active then err_vlen <= 1.
  - A frame with zero lines still completes and sets err_vlen.
- Latency: frame_done is high during the cycle after the 2nd rising edge at or after the one where fv is first sampled low at the pin. line_len updates with the same 2-edge latency relative to lv falling at the pin.
- err_proto: set on any cycle with lv_r=1 and fv_r=0, in every state except SYNC.
- Sticky flags:
  - cleared only by rst or clear_err;
  - if clear_err coincides with a new error condition, the flag ends up 1 (set wins).
- Mid-operation reset: all state is discarded and the FSM returns to SYNC. The first frame_done after reset belongs to a frame whose fv rising edge occurred after reset.
- No output depends combinationally on inputs.

Test Plan (h_active=8, v_active=4, cnt_width=4, word_width=10):
- Nominal: 3 frames of 4 lines x 8 pixels, data=pixel index 0..7 -> per frame line_len=8, line_cnt=4, checksum=112; frame_done 3 single-cycle pulses; frame_cnt=3; all errors 0.
- Short line: line 2 has 7 pixels -> line_len=7 after that line; err_hlen=1 and stays 1 through later good frames; clear_err pulse -> 0.
- Wrong line count: frame with 5 lines -> line_cnt=5, err_vlen=1, frame_done still pulses once; err_hlen stays 0.
- fv falls while lv is high on the 4th line after 8 pixels -> line_len=8, line_cnt=4, exactly one frame_done, no errors.
- Protocol / reset:
  - lv pulsed high for 3 cycles between frames -> err_proto=1.
  - rst asserted mid-frame and released with fv still high -> that frame produces no frame_done; frame_cnt=0 until the next complete frame, then 1.
- Clear collision: clear_err asserted in the same cycle a short line is registered -> err_hlen=1 afterwards.
